// File: rtl/computie_bus_pkg.sv
// Shared types and constants for the Computie bus initiator controller:
// FSM states, bus signal encodings and the per-phase control bundle.
package computie_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    DATA    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  // read_write line encoding
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Active-low transceiver enables
  localparam logic OE_ON  = 1'b0;
  localparam logic OE_OFF = 1'b1;

  // Active-low strobes
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  // Transceiver direction: towards the AD lines (send) or from them
  localparam logic DIR_TO_AD   = 1'b1;
  localparam logic DIR_FROM_AD = 1'b0;

  // Width of the shared phase timer (covers setup 1..15 and timeout up to 255)
  localparam int TIMER_W = 8;

  // Everything the controller drives on the backplane except the data word
  typedef struct packed {
    logic addr_strobe;
    logic data_strobe;
    logic read_write;
    logic send_receive;
    logic addr_oe;
    logic data_oe;
    logic data_dir;
    logic demux_oe;
  } bus_ctl_t;

  // Bus released: strobes high, transceivers off, nothing driven
  function automatic bus_ctl_t ctl_released();
    bus_ctl_t c;
    c.addr_strobe  = STROBE_OFF;
    c.data_strobe  = STROBE_OFF;
    c.read_write   = RW_READ;
    c.send_receive = DIR_FROM_AD;
    c.addr_oe      = OE_OFF;
    c.data_oe      = OE_OFF;
    c.data_dir     = DIR_FROM_AD;
    c.demux_oe     = 1'b0;
    return c;
  endfunction

  // Address phase: AS low, address transceiver driving the latched address
  function automatic bus_ctl_t ctl_addr(input logic write);
    bus_ctl_t c;
    c.addr_strobe  = STROBE_ON;
    c.data_strobe  = STROBE_OFF;
    c.read_write   = write ? RW_WRITE : RW_READ;
    c.send_receive = DIR_TO_AD;
    c.addr_oe      = OE_ON;
    c.data_oe      = OE_OFF;
    c.data_dir     = write ? DIR_TO_AD : DIR_FROM_AD;
    c.demux_oe     = 1'b1;
    return c;
  endfunction

  // Data phase: AS and DS low; demux only drives on writes so reads never contend
  function automatic bus_ctl_t ctl_data(input logic write);
    bus_ctl_t c;
    c.addr_strobe  = STROBE_ON;
    c.data_strobe  = STROBE_ON;
    c.read_write   = write ? RW_WRITE : RW_READ;
    c.send_receive = write ? DIR_TO_AD : DIR_FROM_AD;
    c.addr_oe      = OE_OFF;
    c.data_oe      = OE_ON;
    c.data_dir     = write ? DIR_TO_AD : DIR_FROM_AD;
    c.demux_oe     = write;
    return c;
  endfunction

endpackage

// File: rtl/computie_bus_initiator_ctrl_if.sv
// Request/response handshake plus backplane signals of the bus initiator.
// master: the controller; slave: the core/backplane environment around it.
interface computie_bus_initiator_ctrl_if #(
  parameter int BITWIDTH = 32
);
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [BITWIDTH-1:0] req_addr;
  logic [BITWIDTH-1:0] req_wdata;
  logic                resp_valid;
  logic [BITWIDTH-1:0] resp_rdata;
  logic                resp_error;
  logic                addr_strobe;
  logic                data_strobe;
  logic                read_write;
  logic                data_wait;
  logic                send_receive;
  logic                addr_oe;
  logic                data_oe;
  logic                data_dir;
  logic                demux_oe;
  logic [BITWIDTH-1:0] from_bus;
  logic [BITWIDTH-1:0] to_bus;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, data_wait, from_bus,
    output req_ready, resp_valid, resp_rdata, resp_error,
           addr_strobe, data_strobe, read_write, send_receive,
           addr_oe, data_oe, data_dir, demux_oe, to_bus
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, data_wait, from_bus,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           addr_strobe, data_strobe, read_write, send_receive,
           addr_oe, data_oe, data_dir, demux_oe, to_bus
  );
endinterface

// File: rtl/computie_bus_phase_timer.sv
// Loadable down-counter that saturates at zero. Used for the address setup
// time and, when enabled, the data-phase timeout.
module computie_bus_phase_timer
  import computie_bus_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o
);

  logic [TIMER_W-1:0] cnt_q;

  // Load has priority over decrement; stop at zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TIMER_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/computie_bus_initiator_ctrl.sv
// Computie bus initiator: turns single read/write requests into an
// AS/DS multiplexed bus cycle and returns data or completion status.
// Optional data-phase timeout: define COMPUTIE_BUS_TIMEOUT_EN.
module computie_bus_initiator_ctrl
  import computie_bus_pkg::*;
#(
  parameter int BITWIDTH          = 32,
  parameter int ADDR_SETUP_CYCLES = 1,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input logic                         clk,
  input logic                         reset_n,
  computie_bus_initiator_ctrl_if.master bus
);

  // Timer counts down to zero, so the loaded value is one less than the phase length
  localparam logic [TIMER_W-1:0] ADDR_LOAD    = TIMER_W'(ADDR_SETUP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q;
  bus_ctl_t            ctl_q;
  logic                write_q;
  logic [BITWIDTH-1:0] addr_q;
  logic [BITWIDTH-1:0] wdata_q;
  logic [BITWIDTH-1:0] to_bus_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic [BITWIDTH-1:0] resp_rdata_q;
  logic                wait_meta_q;
  logic                wait_sync_q;
`ifdef COMPUTIE_BUS_TIMEOUT_EN
  logic                resp_error_q;
`endif

  logic               timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic               timer_dec;
  logic               timer_zero;

  computie_bus_phase_timer u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .dec_i      (timer_dec),
    .zero_o     (timer_zero)
  );

  // Two-flop synchroniser for the asynchronous target wait line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_meta_q <= 1'b0;
      wait_sync_q <= 1'b0;
    end else begin
      wait_meta_q <= bus.data_wait;
      wait_sync_q <= wait_meta_q;
    end
  end

  // Timer reload on request accept (setup) and on entering DATA (timeout)
  always_comb begin
    timer_load = 1'b0;
    timer_val  = ADDR_LOAD;
    timer_dec  = 1'b0;
    unique case (state_q)
      IDLE: timer_load = bus.req_valid && req_ready_q;
      ADDR: begin
        if (timer_zero) begin
          timer_load = 1'b1;
          timer_val  = TIMEOUT_LOAD;
        end else begin
          timer_dec = 1'b1;
        end
      end
      DATA:    timer_dec = 1'b1;
      default: ;
    endcase
  end

  // Bus sequencer; every output is registered from the state being entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ctl_q        <= ctl_released();
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      to_bus_q     <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
`ifdef COMPUTIE_BUS_TIMEOUT_EN
      resp_error_q <= 1'b0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            state_q     <= ADDR;
            write_q     <= bus.req_write;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            ctl_q       <= ctl_addr(bus.req_write);
            to_bus_q    <= bus.req_addr;
            req_ready_q <= 1'b0;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ADDR: begin
          if (timer_zero) begin
            state_q  <= DATA;
            ctl_q    <= ctl_data(write_q);
            to_bus_q <= write_q ? wdata_q : '0;
          end
        end
        DATA: begin
          if (!wait_sync_q) begin
            state_q      <= RELEASE;
            ctl_q        <= ctl_released();
            to_bus_q     <= '0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= write_q ? '0 : bus.from_bus;
`ifdef COMPUTIE_BUS_TIMEOUT_EN
            resp_error_q <= 1'b0;
          end else if (timer_zero) begin
            state_q      <= RELEASE;
            ctl_q        <= ctl_released();
            to_bus_q     <= '0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b1;
`endif
          end
        end
        RELEASE: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rdata   = resp_rdata_q;
`ifdef COMPUTIE_BUS_TIMEOUT_EN
  assign bus.resp_error   = resp_error_q;
`else
  assign bus.resp_error   = 1'b0;
`endif
  assign bus.addr_strobe  = ctl_q.addr_strobe;
  assign bus.data_strobe  = ctl_q.data_strobe;
  assign bus.read_write   = ctl_q.read_write;
  assign bus.send_receive = ctl_q.send_receive;
  assign bus.addr_oe      = ctl_q.addr_oe;
  assign bus.data_oe      = ctl_q.data_oe;
  assign bus.data_dir     = ctl_q.data_dir;
  assign bus.demux_oe     = ctl_q.demux_oe;
  assign bus.to_bus       = to_bus_q;

endmodule

// File: tb/tb_computie_bus_initiator_ctrl.sv
// Self-checking bench for computie_bus_initiator_ctrl: a transaction-level
// reference model compared every cycle, plus directed literal checks.
module tb_computie_bus_initiator_ctrl;

  localparam int BW = 32;
  localparam int S  = 1;
  localparam int T  = 8;

  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  computie_bus_initiator_ctrl_if #(.BITWIDTH(BW)) bus_if ();

  computie_bus_initiator_ctrl #(
    .BITWIDTH          (BW),
    .ADDR_SETUP_CYCLES (S),
    .TIMEOUT_CYCLES    (T)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // m_k = clocks since the request was accepted (1 = first address clock)
  bit          m_busy, m_rel, m_ready, m_write, m_err, seen;
  int          m_k;
  logic [31:0] m_addr, m_wdata, m_rdata;
  bit          dw_hist [2];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_rel = 0; m_ready = 0; m_write = 0; m_err = 0; m_k = 0;
      m_addr = 0; m_wdata = 0; m_rdata = 0; dw_hist[0] = 0; dw_hist[1] = 0;
    end else begin
      // wait seen now is the level sampled two clocks earlier
      seen = dw_hist[1];
      dw_hist[1] = dw_hist[0];
      dw_hist[0] = bus_if.data_wait;
      if (m_rel) begin
        m_rel = 0; m_busy = 0; m_ready = 1;
      end else if (m_busy) begin
        if (m_k > S && !seen) begin
          m_rel = 1; m_err = 0;
          m_rdata = m_write ? 32'h0 : bus_if.from_bus;
        end
`ifdef COMPUTIE_BUS_TIMEOUT_EN
        else if (m_k - S == T) begin
          m_rel = 1; m_err = 1; m_rdata = 32'h0;
        end
`endif
        else m_k++;
      end else if (bus_if.req_valid && m_ready) begin
        m_busy = 1; m_k = 1; m_ready = 0;
        m_write = bus_if.req_write; m_addr = bus_if.req_addr; m_wdata = bus_if.req_wdata;
      end else begin
        m_ready = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit ia, id, cyc;
    ia  = m_busy && !m_rel && (m_k <= S);
    id  = m_busy && !m_rel && (m_k > S);
    cyc = ia || id;
    chk1("addr_strobe", bus_if.addr_strobe, !cyc);
    chk1("data_strobe", bus_if.data_strobe, !id);
    chk1("read_write", bus_if.read_write, cyc ? !m_write : 1'b1);
    chk1("send_receive", bus_if.send_receive, ia || (id && m_write));
    chk1("addr_oe", bus_if.addr_oe, !ia);
    chk1("data_oe", bus_if.data_oe, !id);
    chk1("data_dir", bus_if.data_dir, cyc ? m_write : 1'b0);
    chk1("demux_oe", bus_if.demux_oe, ia || (id && m_write));
    chk32("to_bus", bus_if.to_bus, ia ? m_addr : ((id && m_write) ? m_wdata : 32'h0));
    chk1("req_ready", bus_if.req_ready, m_ready);
    chk1("resp_valid", bus_if.resp_valid, m_rel);
    if (m_rel) begin
      chk32("resp_rdata", bus_if.resp_rdata, m_rdata);
      chk1("resp_error", bus_if.resp_error, m_err);
    end
  end

  // ---------------- directed stimulus ----------------
  logic        obs_as [0:31], obs_ds [0:31], obs_rv [0:31], obs_rdy [0:31];
  logic        obs_dmx [0:31], obs_rw [0:31], obs_err [0:31];
  logic [31:0] obs_to [0:31], obs_rd [0:31];

  // Starts in cycle 0 (just after a clock). data_wait is high from cycle 0
  // and drops in cycle wait_clr (0: never high, negative: stuck high).
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] fb, input int wait_clr, input bit hold,
                         input int ncyc);
    bus_if.req_valid = 1'b1;
    bus_if.req_write = wr;
    bus_if.req_addr  = addr;
    bus_if.req_wdata = wdata;
    bus_if.from_bus  = fb;
    bus_if.data_wait = (wait_clr != 0);
    for (int c = 0; c <= ncyc; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 1 && !hold) bus_if.req_valid = 1'b0;
        if (c == wait_clr) bus_if.data_wait = 1'b0;
      end
      @(negedge clk);
      obs_as[c] = bus_if.addr_strobe;  obs_ds[c]  = bus_if.data_strobe;
      obs_rv[c] = bus_if.resp_valid;   obs_rdy[c] = bus_if.req_ready;
      obs_dmx[c] = bus_if.demux_oe;    obs_rw[c]  = bus_if.read_write;
      obs_err[c] = bus_if.resp_error;  obs_to[c]  = bus_if.to_bus;
      obs_rd[c]  = bus_if.resp_rdata;
    end
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
  endtask

  initial begin
    int rv_cnt, rdy_cnt;
    reset_n = 1'b0;
    bus_if.req_valid = 0; bus_if.req_write = 0; bus_if.req_addr = 0;
    bus_if.req_wdata = 0; bus_if.data_wait = 0; bus_if.from_bus = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk1("ready_before_first_clock", bus_if.req_ready, 1'b0);
    @(posedge clk); #1;

    // Write 0x1000 <- DEADBEEF, zero wait
    run_txn(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 5);
    $display("txn write addr=00001000 wdata=deadbeef wait=0");
    chk1("wr_ready_c0", obs_rdy[0], 1'b1);
    chk1("wr_as_c1", obs_as[1], 1'b0);
    chk1("wr_ds_c1", obs_ds[1], 1'b1);
    chk32("wr_to_bus_c1", obs_to[1], 32'h0000_1000);
    chk1("wr_as_c2", obs_as[2], 1'b0);
    chk1("wr_ds_c2", obs_ds[2], 1'b0);
    chk32("wr_to_bus_c2", obs_to[2], 32'hDEAD_BEEF);
    chk1("wr_rw_c2", obs_rw[2], 1'b0);
    chk1("wr_rv_c2", obs_rv[2], 1'b0);
    chk1("wr_rv_c3", obs_rv[3], 1'b1);
    chk1("wr_err_c3", obs_err[3], 1'b0);
    chk1("wr_as_c3", obs_as[3], 1'b1);

    // Read 0x40 with three synchronised wait clocks
    run_txn(1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 3, 1'b0, 8);
    $display("txn read addr=00000040 wait=3 from_bus=12345678");
    chk1("rdw_demux_c1", obs_dmx[1], 1'b1);
    for (int c = 2; c <= 5; c++) chk1("rdw_demux_data", obs_dmx[c], 1'b0);
    chk1("rdw_ds_c5", obs_ds[5], 1'b0);
    chk1("rdw_rv_c5", obs_rv[5], 1'b0);
    chk1("rdw_rv_c6", obs_rv[6], 1'b1);
    chk32("rdw_rdata_c6", obs_rd[6], 32'h1234_5678);

    // Read zero wait
    run_txn(1'b0, 32'hA5A5_0000, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 5);
    $display("txn read addr=a5a50000 wait=0 from_bus=cafef00d");
    chk1("rd_rv_c3", obs_rv[3], 1'b1);
    chk32("rd_rdata_c3", obs_rd[3], 32'hCAFE_F00D);

    // Write with one wait clock: response data must be zero
    run_txn(1'b1, 32'h0000_0020, 32'h0BAD_F00D, 32'h7777_7777, 1, 1'b0, 6);
    $display("txn write addr=00000020 wdata=0badf00d wait=1");
    chk1("wrw_rv_c4", obs_rv[4], 1'b1);
    chk32("wrw_rdata_c4", obs_rd[4], 32'h0);

    // Back-to-back with req_valid held high
    run_txn(1'b1, 32'h0000_0080, 32'h0000_0001, 32'h0, 0, 1'b1, 9);
    $display("txn back-to-back writes addr=00000080");
    rdy_cnt = 0;
    for (int c = 1; c <= 7; c++) rdy_cnt += obs_rdy[c];
    chk32("b2b_idle_clocks", 32'(rdy_cnt), 32'd1);
    chk1("b2b_ready_c4", obs_rdy[4], 1'b1);
    chk1("b2b_as_c4", obs_as[4], 1'b1);
    chk1("b2b_ds_c4", obs_ds[4], 1'b1);
    chk1("b2b_as_c5", obs_as[5], 1'b0);
    chk1("b2b_rv_c3", obs_rv[3], 1'b1);
    chk1("b2b_rv_c7", obs_rv[7], 1'b1);
    repeat (6) @(posedge clk);
    #1;

    // Reset asserted mid-DATA of a read
    bus_if.req_valid = 1; bus_if.req_write = 0; bus_if.req_addr = 32'h44;
    bus_if.from_bus = 32'h55; bus_if.data_wait = 1;
    @(posedge clk); #1 bus_if.req_valid = 0;
    @(posedge clk); @(posedge clk); #3;
    chk1("rst_ds_before", bus_if.data_strobe, 1'b0);
    reset_n = 1'b0;
    #1;
    $display("txn reset pulse during read data phase");
    chk1("rst_as", bus_if.addr_strobe, 1'b1);
    chk1("rst_ds", bus_if.data_strobe, 1'b1);
    chk1("rst_rw", bus_if.read_write, 1'b1);
    chk1("rst_addr_oe", bus_if.addr_oe, 1'b1);
    chk1("rst_data_oe", bus_if.data_oe, 1'b1);
    chk1("rst_demux_oe", bus_if.demux_oe, 1'b0);
    chk1("rst_data_dir", bus_if.data_dir, 1'b0);
    chk1("rst_send_receive", bus_if.send_receive, 1'b0);
    chk32("rst_to_bus", bus_if.to_bus, 32'h0);
    chk1("rst_req_ready", bus_if.req_ready, 1'b0);
    chk1("rst_resp_valid", bus_if.resp_valid, 1'b0);
    chk32("rst_resp_rdata", bus_if.resp_rdata, 32'h0);
    chk1("rst_resp_error", bus_if.resp_error, 1'b0);
    bus_if.data_wait = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    run_txn(1'b0, 32'h0000_0044, 32'h0, 32'h0000_0099, 0, 1'b0, 5);
    $display("txn read after reset addr=00000044");
    chk1("post_rst_rv_c3", obs_rv[3], 1'b1);
    chk32("post_rst_rdata_c3", obs_rd[3], 32'h0000_0099);

    // data_wait stuck high
`ifdef COMPUTIE_BUS_TIMEOUT_EN
    run_txn(1'b0, 32'h0000_0060, 32'h0, 32'hFFFF_0000, -1, 1'b0, 12);
    $display("txn read addr=00000060 wait stuck (timeout %0d)", T);
    chk1("to_rv_c9", obs_rv[9], 1'b0);
    chk1("to_ds_c9", obs_ds[9], 1'b0);
    chk1("to_rv_c10", obs_rv[10], 1'b1);
    chk1("to_err_c10", obs_err[10], 1'b1);
    chk32("to_rdata_c10", obs_rd[10], 32'h0);
    chk1("to_ds_c10", obs_ds[10], 1'b1);
`else
    run_txn(1'b0, 32'h0000_0060, 32'h0, 32'hFFFF_0000, -1, 1'b0, 3);
    rv_cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      rv_cnt += bus_if.resp_valid;
    end
    $display("txn read addr=00000060 wait stuck (no timeout) responses=%0d", rv_cnt);
    chk32("stuck_no_resp", 32'(rv_cnt), 32'd0);
    chk1("stuck_ds_low", bus_if.data_strobe, 1'b0);
`endif
    @(posedge clk); #1;
    reset_n = 1'b0;
    bus_if.data_wait = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_txn(1'b1, 32'h0000_0010, 32'h1357_9BDF, 32'h0, 0, 1'b0, 5);
    $display("txn write addr=00000010 wdata=13579bdf recovery");
    chk1("rec_rv_c3", obs_rv[3], 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/computie_bus_initiator_ctrl.md
Name: computie_bus_initiator_ctrl

Overview:
Bus-master end of the Computie multiplexed address/data bus. It is the counterpart of the receiver controller.
- Accepts single read/write requests on an internal valid/ready interface.
- Runs the bus sequence: address phase (AS low, DS high), data phase (AS low, DS low), release.
- Drives the transceiver and demux controls and returns read data or completion status.
- Sits between a CPU/DMA core in the FPGA and the external backplane transceivers.

Parameters:
BITWIDTH, 32, width of the address and data words and the multiplexed bus.
ADDR_SETUP_CYCLES, 1, clocks the address phase is held before DS asserts (range 1..15).
TIMEOUT_CYCLES, 255, data-phase clocks before abort (used only with COMPUTIE_BUS_TIMEOUT_EN).

Ports:
clk  input  1  system clock; all state updates on posedge, so negedge-sampling receivers see stable signals.
reset_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  high only in IDLE.
req_write  input  1  1 = write, 0 = read.
req_addr  input  BITWIDTH  target address.
req_wdata  input  BITWIDTH  write data.
resp_valid  output  1  one-cycle completion pulse.
resp_rdata  output  BITWIDTH  read data, valid with resp_valid.
resp_error  output  1  timeout abort, valid with resp_valid.
addr_strobe  output  1  active-low AS.
data_strobe  output  1  active-low DS.
read_write  output  1  1 = read, 0 = write.
data_wait  input  1  target not ready (active high); synchronised by 2 flops internally.
send_receive  output  1  transceiver direction; 1 = send.
addr_oe  output  1  active-low address transceiver enable.
data_oe  output  1  active-low data transceiver enable.
data_dir  output  1  equals !read_write while in a bus cycle.
demux_oe  output  1  1 = to_bus drives the multiplexed lines.
from_bus  input  BITWIDTH  demuxed bus input.
to_bus  output  BITWIDTH  demuxed bus output.

Behaviour:
- Reset (asynchronous, also mid-cycle) forces the following at once, and the state returns to IDLE:
  - addr_strobe = 1, data_strobe = 1, read_write = 1.
  - addr_oe = 1, data_oe = 1, demux_oe = 0, data_dir = 0, send_receive = 0.
  - to_bus = 0, req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_error = 0.
  - req_ready rises on the first clock after release.
- IDLE: bus released as in reset; req_ready = 1. When req_valid && req_ready, latch write/addr/wdata and go to ADDR.
- ADDR (ADDR_SETUP_CYCLES clocks):
  - send_receive = 1, addr_oe = 0, demux_oe = 1, to_bus = latched addr.
  - addr_strobe = 0, data_strobe = 1, read_write = !write.
  - Then go to DATA.
- DATA:
  - addr_oe = 1, data_oe = 0, data_dir = !read_write, data_strobe = 0.
  - Write: demux_oe = 1, to_bus = wdata, send_receive = 1.
  - Read: demux_oe = 0, send_receive = 0.
  - DS is held for at least 1 clock. On the first clock with synchronised data_wait = 0, capture from_bus (reads) and go to RELEASE.
- RELEASE (1 clock):
  - Strobes and enables return to reset values, demux_oe = 0.
  - resp_valid = 1 with resp_rdata (0 for writes) and resp_error.
  - Next state is IDLE.
- Latency with zero wait: req accepted at cycle 0, AS low at cycle 1, DS low at cycle 1 + ADDR_SETUP_CYCLES, resp_valid at cycle 2 + ADDR_SETUP_CYCLES. Each synchronised wait clock adds 1.
- req_valid is ignored outside IDLE. Only one transaction is outstanding at a time.
- Back-to-back requests: the earliest acceptance is the clock after resp_valid. This guarantees at least 1 idle clock with strobes high between cycles.
- to_bus is never driven (demux_oe = 0) while data_oe = 0 on a read, which prevents bus contention.

Optional Feature:
COMPUTIE_BUS_TIMEOUT_EN
- Defined: a DATA-phase counter starts at 0 on entry. If synchronised data_wait is still 1 after TIMEOUT_CYCLES clocks, go to RELEASE with resp_error = 1 and resp_rdata = 0.
- Undefined: DATA waits indefinitely, the counter is absent, and resp_error is tied to 0.

Decomposition:
- computie_bus_pkg holds:
  - the state enum: IDLE, ADDR, DATA, RELEASE;
  - constants for the RW_READ/RW_WRITE encodings;
  - constants for the active-low OE_ON/OE_OFF levels;
  - the DIR_TO_AD/DIR_FROM_AD values.
- One sub-module: computie_bus_phase_timer, a loadable down-counter shared for ADDR setup and the optional timeout.

Test Plan:
- Write, addr 0x0000_1000, wdata 0xDEADBEEF, data_wait = 0, ADDR_SETUP_CYCLES = 1 -> AS low cycles 1-2, to_bus 0x1000 in cycle 1, DS low in cycle 2 with to_bus DEADBEEF and read_write = 0, resp_valid in cycle 3, resp_error = 0.
- Read, addr 0x40, data_wait held high 3 synced clocks, from_bus = 0x12345678 -> demux_oe = 0 throughout DATA, resp_rdata = 0x12345678, resp_valid 3 clocks later than the zero-wait case.
- Back-to-back requests with req_valid held high -> req_ready = 0 during the cycle, exactly 1 idle clock with both strobes high between transactions.
- Reset pulse asserted mid-DATA of a read -> all outputs at reset values immediately without a clock, no resp_valid, next request completes normally.
- TIMEOUT_EN defined, TIMEOUT_CYCLES = 8, data_wait stuck high -> resp_valid with resp_error = 1, resp_rdata = 0, DS released. Without the macro: no response after 1000 clocks.
